// File: rtl/push_down_stack.sv
// push_down_stack: LIFO stack built on a single-port synchronous RAM.
// Ports: Clk, Rst (async, active-high), En, PushPop (0=push, 1=pop),
//        data_i (push word), data_o (last popped word), empty, full.
module push_down_stack #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              En,
    input  logic              PushPop,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              empty,
    output logic              full
);

    localparam logic [ADDR_W:0] SP_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] SP_MAX = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W:0]   sp;
    logic [ADDR_W:0]   sp_nxt;
    logic [ADDR_W:0]   sp_dec;
    logic [ADDR_W-1:0] addr;
    logic              push_ok;
    logic              pop_ok;

    // Registered flags act as the guards, so over/underflow is impossible.
    assign push_ok = En & ~PushPop & ~full & ~Rst;
    assign pop_ok  = En & PushPop & ~empty & ~Rst;
    assign sp_dec  = sp - SP_ONE;

    // Single RAM port: push writes slot sp, pop reads slot sp-1.
    assign addr = PushPop ? sp_dec[ADDR_W-1:0] : sp[ADDR_W-1:0];

    always_comb begin
        sp_nxt = sp;
        unique case (1'b1)
            push_ok: sp_nxt = sp + SP_ONE;
            pop_ok:  sp_nxt = sp_dec;
            default: sp_nxt = sp;
        endcase
    end

    // RAM array has no reset; contents survive Rst.
    always_ff @(posedge Clk) begin
        if (push_ok) begin
            mem[addr] <= data_i;
        end
    end

    // Flags come from sp_nxt so they line up with the new sp.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sp     <= '0;
            data_o <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            sp    <= sp_nxt;
            empty <= (sp_nxt == '0);
            full  <= (sp_nxt == SP_MAX);
            if (pop_ok) begin
                data_o <= mem[addr];
            end
        end
    end

endmodule

// File: tb/tb_push_down_stack.sv
// tb_push_down_stack: directed self-checking bench for push_down_stack.
// Each scenario task drives stimulus and checks outputs inline.
module tb_push_down_stack;

    logic       Clk;
    logic       Rst;
    logic       En;
    logic       PushPop;
    logic [7:0] data_i;
    logic [7:0] data_o;
    logic       empty;
    logic       full;

    int n_checks;
    int n_fail;

    push_down_stack #(
        .DATA_W(8),
        .DEPTH (1024),
        .ADDR_W(10)
    ) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .En     (En),
        .PushPop(PushPop),
        .data_i (data_i),
        .data_o (data_o),
        .empty  (empty),
        .full   (full)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // One clocked operation: drive at negedge, return 1ns after posedge.
    task automatic op(input logic e, input logic pp, input logic [7:0] d);
        @(negedge Clk);
        En      = e;
        PushPop = pp;
        data_i  = d;
        @(posedge Clk);
        #1;
        En = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        #2;
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        Rst = 1'b1;
        #1;
        n_checks++;
        if (data_o !== 8'h00) begin
            $display("FAIL reset_data_o: got %h expected %h", data_o, 8'h00);
            n_fail++;
        end
        n_checks++;
        if (empty !== 1'b1) begin
            $display("FAIL reset_empty: got %b expected %b", empty, 1'b1);
            n_fail++;
        end
        n_checks++;
        if (full !== 1'b0) begin
            $display("FAIL reset_full: got %b expected %b", full, 1'b0);
            n_fail++;
        end
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic test_lifo();
        logic [7:0] exp_vals [3];
        exp_vals[0] = 8'd3;
        exp_vals[1] = 8'd2;
        exp_vals[2] = 8'd1;
        do_reset();
        op(1'b1, 1'b0, 8'd1);
        n_checks++;
        if (empty !== 1'b0) begin
            $display("FAIL lifo_empty_after_push: got %b expected %b", empty, 1'b0);
            n_fail++;
        end
        op(1'b1, 1'b0, 8'd2);
        op(1'b1, 1'b0, 8'd3);
        for (int i = 0; i < 3; i++) begin
            op(1'b1, 1'b1, 8'h00);
            n_checks++;
            if (data_o !== exp_vals[i]) begin
                $display("FAIL lifo_pop%0d: got %h expected %h", i, data_o, exp_vals[i]);
                n_fail++;
            end
        end
        n_checks++;
        if (empty !== 1'b1) begin
            $display("FAIL lifo_empty_end: got %b expected %b", empty, 1'b1);
            n_fail++;
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 1; i <= 1024; i++) begin
            op(1'b1, 1'b0, 8'(i));
            if (i == 1023) begin
                n_checks++;
                if (full !== 1'b0) begin
                    $display("FAIL fill_full_1023: got %b expected %b", full, 1'b0);
                    n_fail++;
                end
            end
        end
        n_checks++;
        if (full !== 1'b1) begin
            $display("FAIL fill_full_1024: got %b expected %b", full, 1'b1);
            n_fail++;
        end
        n_checks++;
        if (empty !== 1'b0) begin
            $display("FAIL fill_empty: got %b expected %b", empty, 1'b0);
            n_fail++;
        end
        op(1'b1, 1'b0, 8'hAA);
        n_checks++;
        if (full !== 1'b1) begin
            $display("FAIL fill_overflow_full: got %b expected %b", full, 1'b1);
            n_fail++;
        end
        op(1'b1, 1'b1, 8'h00);
        n_checks++;
        if (data_o !== 8'h00) begin
            $display("FAIL fill_pop_top: got %h expected %h", data_o, 8'h00);
            n_fail++;
        end
        n_checks++;
        if (full !== 1'b0) begin
            $display("FAIL fill_full_after_pop: got %b expected %b", full, 1'b0);
            n_fail++;
        end
        op(1'b1, 1'b1, 8'h00);
        n_checks++;
        if (data_o !== 8'hFF) begin
            $display("FAIL fill_pop_second: got %h expected %h", data_o, 8'hFF);
            n_fail++;
        end
    endtask

    task automatic test_underflow();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            op(1'b1, 1'b1, 8'h00);
            n_checks++;
            if (data_o !== 8'h00) begin
                $display("FAIL under_data_o%0d: got %h expected %h", i, data_o, 8'h00);
                n_fail++;
            end
            n_checks++;
            if (empty !== 1'b1) begin
                $display("FAIL under_empty%0d: got %b expected %b", i, empty, 1'b1);
                n_fail++;
            end
        end
        op(1'b1, 1'b0, 8'h5A);
        op(1'b1, 1'b1, 8'h00);
        n_checks++;
        if (data_o !== 8'h5A) begin
            $display("FAIL under_pop: got %h expected %h", data_o, 8'h5A);
            n_fail++;
        end
        n_checks++;
        if (empty !== 1'b1) begin
            $display("FAIL under_empty_end: got %b expected %b", empty, 1'b1);
            n_fail++;
        end
    endtask

    task automatic test_enable_hold();
        do_reset();
        op(1'b1, 1'b0, 8'h11);
        for (int i = 0; i < 5; i++) begin
            op(1'b0, 1'b1, 8'hC3);
            n_checks++;
            if (data_o !== 8'h00 || empty !== 1'b0 || full !== 1'b0) begin
                $display("FAIL hold%0d: got d=%h e=%b f=%b expected d=00 e=0 f=0",
                         i, data_o, empty, full);
                n_fail++;
            end
        end
        op(1'b1, 1'b1, 8'h00);
        n_checks++;
        if (data_o !== 8'h11) begin
            $display("FAIL hold_pop: got %h expected %h", data_o, 8'h11);
            n_fail++;
        end
        n_checks++;
        if (empty !== 1'b1) begin
            $display("FAIL hold_empty: got %b expected %b", empty, 1'b1);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            op(1'b1, 1'b0, 8'(8'h20 + i));
        end
        op(1'b1, 1'b1, 8'h00);
        n_checks++;
        if (data_o !== 8'h29) begin
            $display("FAIL mid_pre_pop: got %h expected %h", data_o, 8'h29);
            n_fail++;
        end
        #2;
        Rst = 1'b1;
        #1;
        n_checks++;
        if (empty !== 1'b1 || data_o !== 8'h00) begin
            $display("FAIL mid_async: got e=%b d=%h expected e=1 d=00", empty, data_o);
            n_fail++;
        end
        @(negedge Clk);
        Rst = 1'b0;
        op(1'b1, 1'b1, 8'h00);
        n_checks++;
        if (data_o !== 8'h00 || empty !== 1'b1) begin
            $display("FAIL mid_pop_ignored: got d=%h e=%b expected d=00 e=1", data_o, empty);
            n_fail++;
        end
        op(1'b1, 1'b0, 8'h77);
        op(1'b1, 1'b1, 8'h00);
        n_checks++;
        if (data_o !== 8'h77) begin
            $display("FAIL mid_pop_after: got %h expected %h", data_o, 8'h77);
            n_fail++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        Rst      = 1'b0;
        En       = 1'b0;
        PushPop  = 1'b0;
        data_i   = 8'h00;
        test_reset();
        test_lifo();
        test_underflow();
        test_enable_hold();
        test_fill();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
